fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction ROM address width.
REQ-002 SHALL have parameter INSTR_W, default 9, instruction word width.
REQ-003 SHALL have parameter HALT_INSTR, default 9'h1FF, encoding that self-halts the sequencer.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-006 SHALL have port start  in  1  begin fetching from start_pc; sampled only in IDLE or HALTED.
REQ-007 SHALL have port start_pc  in  ADDR_W  initial fetch address.
REQ-008 SHALL have port rom_addr  out  ADDR_W  address to the combinational instruction ROM; equals pc register.
REQ-009 SHALL have port rom_instr  in  INSTR_W  ROM data for rom_addr, same cycle.
REQ-010 SHALL have port instr_valid  out  1  output register holds an instruction.
REQ-011 SHALL have port instr  out  INSTR_W  held instruction.
REQ-012 SHALL have port instr_pc  out  ADDR_W  address the held instruction came from.
REQ-013 SHALL have port instr_ready  in  1  consumer accepts instr this cycle.
REQ-014 SHALL have port branch_taken  in  1  redirect request.
REQ-015 SHALL have port branch_target  in  ADDR_W  redirect address.
REQ-016 SHALL have port halt_req  in  1  external stop request.
REQ-017 SHALL have port busy  out  1  high in RUN or DRAIN.
REQ-018 SHALL have port halted  out  1  high in HALTED.
REQ-019 SHALL have port fetch_count  out  16  instructions accepted since last start; saturates at 16'hFFFF.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN, HALTED.
REQ-021 IDLE/HALTED + start: pc <= start_pc, fetch_count <= 0, output register cleared, next state RUN.
REQ-022 Transfer = instr_valid && instr_ready; fetch_count increments by 1 on each transfer, saturating.
REQ-023 RUN load condition: !instr_valid || transfer; on load instr <= rom_instr, instr_pc <= pc, instr_valid <= 1, pc <= pc+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
REQ-024 RUN, instr_valid && !instr_ready: instr, instr_pc, pc held stable.
REQ-025 Latency: start in cycle N -> first instr_valid in cycle N+2 with instr = ROM[start_pc].
REQ-026 RUN + branch_taken: output register discarded (instr_valid <= 0, no transfer counted even if instr_ready), pc <= branch_target, no load this cycle; next instr_valid two cycles later with ROM[branch_target].
REQ-027 Loaded word equal to HALT_INSTR: loaded and presented normally, then state DRAIN, no further loads.
REQ-028 RUN + halt_req (no branch): no load this cycle, state DRAIN.
REQ-029 RUN + branch_taken + halt_req same cycle: flush and pc <= branch_target per REQ-026, state HALTED directly.
REQ-030 DRAIN: no loads; when !instr_valid or transfer occurs, instr_valid <= 0 and state HALTED.
REQ-031 branch_taken, halt_req ignored outside RUN; start ignored in RUN and DRAIN.
REQ-032 busy and halted SHALL be registered state decodes, never both high.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, pc 0, instr_valid 0, instr 0, instr_pc 0, fetch_count 0, busy 0, halted 0, regardless of operation in progress.
REQ-034 After rst_n deasserts, block SHALL remain IDLE until start.

Verification
REQ-035 Reset then start, start_pc=0, instr_ready=1, ROM 0..3 distinct -> valid from cycle N+2, instr_pc 0,1,2,3 on consecutive cycles, fetch_count=4 after four accepts.
REQ-036 instr_ready=0 for 3 cycles mid-stream -> instr/instr_pc stable, rom_addr stable, no count change; resume without skip or duplicate.
REQ-037 start_pc=8'hFE, ready=1 -> instr_pc sequence FE, FF, 00, 01.
REQ-038 branch_taken with target 8'h40 while instr_valid -> next cycle instr_valid=0, following cycle instr_pc=8'h40; discarded word not counted.
REQ-039 ROM[5]=HALT_INSTR, start_pc=3 -> words 3,4,5 delivered, halted=1 one cycle after word 5 accepted, rom_addr stays 6.
REQ-040 rst_n pulsed low in RUN with instr_valid=1 -> instr_valid, busy, fetch_count 0 asynchronously; start afterward restarts cleanly.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a combinational instruction ROM from a
// start address, presents one word at a time through a valid/ready output
// register, and supports redirects, external stop requests and a self-halt
// encoding.
module fetch_sequencer #(
    parameter int                  ADDR_W     = 8,
    parameter int                  INSTR_W    = 9,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = 9'h1FF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_req,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic                 r_instr_valid;
    logic [INSTR_W-1:0]   r_instr;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic [15:0]          r_fetch_count;
    logic                 r_busy;
    logic                 r_halted;

    logic                 w_transfer;
    logic                 w_load_ok;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [15:0]          w_count_inc;

    // Handshake and arithmetic helpers shared by all states
    always_comb begin
        w_transfer  = r_instr_valid && instr_ready;
        w_load_ok   = !r_instr_valid || w_transfer;
        w_pc_inc    = r_pc + 1'b1;
        w_count_inc = (r_fetch_count == 16'hFFFF) ? r_fetch_count
                                                  : r_fetch_count + 16'd1;
    end

    // Sequencer FSM with its datapath; busy/halted are decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fetch_count <= '0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc          <= start_pc;
                        r_fetch_count <= '0;
                        r_instr_valid <= 1'b0;
                        r_instr       <= '0;
                        r_instr_pc    <= '0;
                        r_state       <= S_RUN;
                        r_busy        <= 1'b1;
                        r_halted      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (branch_taken) begin
                        // Redirect flushes the held word without counting it
                        r_instr_valid <= 1'b0;
                        r_pc          <= branch_target;
                        if (halt_req) begin
                            r_state  <= S_HALTED;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end
                    end else if (halt_req) begin
                        // Stop fetching; a word handed over this cycle still counts
                        if (w_transfer) begin
                            r_fetch_count <= w_count_inc;
                            r_instr_valid <= 1'b0;
                        end
                        r_state <= S_DRAIN;
                    end else begin
                        if (w_transfer) begin
                            r_fetch_count <= w_count_inc;
                        end
                        if (w_load_ok) begin
                            r_instr       <= rom_instr;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                            if (rom_instr == HALT_INSTR) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait for the last held word to leave, then stop
                    if (w_transfer) begin
                        r_fetch_count <= w_count_inc;
                    end
                    if (w_load_ok) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_HALTED;
                        r_busy        <= 1'b0;
                        r_halted      <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_count = r_fetch_count;
    assign busy        = r_busy;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM model, scoreboard of expected words checked
// on every accepted transfer, a table of straight-line runs and hand-written
// sequences for stalls, redirects, self-halt and asynchronous reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_pc;
    logic [7:0]  rom_addr;
    logic [8:0]  rom_instr;
    logic        instr_valid;
    logic [8:0]  instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        halt_req;
    logic        busy;
    logic        halted;
    logic [15:0] fetch_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [8:0] rom_mem [256];

    typedef struct packed {
        logic [7:0] pc;
        logic [8:0] ins;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0]  spc;
        int          n;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_addr;
    } vec_t;
    vec_t vecs [5];

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(9), .HALT_INSTR(9'h1FF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_pc     (start_pc),
        .rom_addr     (rom_addr),
        .rom_instr    (rom_instr),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .busy         (busy),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    assign rom_instr = rom_mem[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a);
        exp_t e;
        e.pc  = a;
        e.ins = rom_mem[a];
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every accepted (non-flushed) word must match the head
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !branch_taken) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_xfer", {24'd0, instr_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("xfer pc=%02h instr=%03h exp_pc=%02h exp_instr=%03h",
                         instr_pc, instr, e.pc, e.ins);
                chk("xfer_pc", {24'd0, instr_pc}, {24'd0, e.pc});
                chk("xfer_instr", {23'd0, instr}, {23'd0, e.ins});
            end
        end
    end

    // Start at spc, accept n words back to back, stop with halt_req on the last accept
    task automatic run_vec(input logic [7:0] spc, input int n,
                           input logic [15:0] exp_cnt, input logic [7:0] exp_addr);
        for (int k = 0; k < n; k++) push_exp(spc + k[7:0]);
        instr_ready = 1'b1;
        start_pc    = spc;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("run_first_cycle_valid", {31'd0, instr_valid}, 32'd0);
        chk("run_busy", {31'd0, busy}, 32'd1);
        repeat (n) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        chk("run_halted", {31'd0, halted}, 32'd1);
        chk("run_not_busy", {31'd0, busy}, 32'd0);
        chk("run_count", {16'd0, fetch_count}, {16'd0, exp_cnt});
        chk("run_rom_addr", {24'd0, rom_addr}, {24'd0, exp_addr});
        chk("run_sb_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = {1'b0, i[7:0] ^ 8'h5A};
        vecs[0] = '{spc: 8'h00, n: 4,  exp_cnt: 16'd4,  exp_addr: 8'h04};
        vecs[1] = '{spc: 8'hFE, n: 4,  exp_cnt: 16'd4,  exp_addr: 8'h02};
        vecs[2] = '{spc: 8'h10, n: 1,  exp_cnt: 16'd1,  exp_addr: 8'h11};
        vecs[3] = '{spc: 8'h80, n: 7,  exp_cnt: 16'd7,  exp_addr: 8'h87};
        vecs[4] = '{spc: 8'hF0, n: 20, exp_cnt: 16'd20, exp_addr: 8'h04};

        rst_n = 1'b0; start = 1'b0; start_pc = '0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
        #23;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", {16'd0, fetch_count}, 32'd0);
        chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        rst_n = 1'b1;
        // Stays idle without start even with other controls active
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h33; halt_req = 1'b1;
        repeat (3) tick();
        branch_taken = 1'b0; halt_req = 1'b0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_halted", {31'd0, halted}, 32'd0);
        chk("idle_rom_addr", {24'd0, rom_addr}, 32'd0);
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);

        // Table of straight-line runs, including address wrap
        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v].spc, vecs[v].n, vecs[v].exp_cnt, vecs[v].exp_addr);
        end

        // Consumer stall for three cycles in mid-stream
        for (int k = 0; k < 6; k++) push_exp(8'h20 + k[7:0]);
        instr_ready = 1'b1; start_pc = 8'h20; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", {24'd0, instr_pc}, 32'h22);
            chk("stall_instr", {23'd0, instr}, {23'd0, rom_mem[8'h22]});
            chk("stall_rom_addr", {24'd0, rom_addr}, 32'h23);
            chk("stall_count", {16'd0, fetch_count}, 32'd2);
            @(posedge clk); #1;
        end
        instr_ready = 1'b1;
        repeat (3) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0; tick();
        chk("stall_final_count", {16'd0, fetch_count}, 32'd6);
        chk("stall_sb_empty", sb_q.size(), 32'd0);

        // Redirect while a word is held; the flushed word is not counted
        push_exp(8'h30); push_exp(8'h40); push_exp(8'h41);
        start_pc = 8'h30; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        branch_taken = 1'b1; branch_target = 8'h40;
        tick();
        branch_taken = 1'b0;
        chk("br_valid_dropped", {31'd0, instr_valid}, 32'd0);
        chk("br_rom_addr", {24'd0, rom_addr}, 32'h40);
        chk("br_count_no_flush", {16'd0, fetch_count}, 32'd1);
        tick();
        chk("br_target_pc", {24'd0, instr_pc}, 32'h40);
        tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0; tick();
        chk("br_final_count", {16'd0, fetch_count}, 32'd3);
        chk("br_sb_empty", sb_q.size(), 32'd0);

        // Self-halt on the halt encoding at address 5
        rom_mem[5] = 9'h1FF;
        push_exp(8'h03); push_exp(8'h04); push_exp(8'h05);
        start_pc = 8'h03; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("sh_word5_pc", {24'd0, instr_pc}, 32'h05);
        chk("sh_busy_drain", {31'd0, busy}, 32'd1);
        chk("sh_not_halted_yet", {31'd0, halted}, 32'd0);
        tick();
        chk("sh_halted", {31'd0, halted}, 32'd1);
        chk("sh_rom_addr", {24'd0, rom_addr}, 32'h06);
        chk("sh_count", {16'd0, fetch_count}, 32'd3);
        tick();
        chk("sh_rom_addr_hold", {24'd0, rom_addr}, 32'h06);
        chk("sh_sb_empty", sb_q.size(), 32'd0);
        rom_mem[5] = {1'b0, 8'h05 ^ 8'h5A};

        // Redirect and stop in the same cycle goes straight to halted
        push_exp(8'h50);
        start_pc = 8'h50; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        branch_taken = 1'b1; halt_req = 1'b1; branch_target = 8'h70;
        tick();
        branch_taken = 1'b0; halt_req = 1'b0;
        chk("bh_halted", {31'd0, halted}, 32'd1);
        chk("bh_busy", {31'd0, busy}, 32'd0);
        chk("bh_valid", {31'd0, instr_valid}, 32'd0);
        chk("bh_rom_addr", {24'd0, rom_addr}, 32'h70);
        chk("bh_count", {16'd0, fetch_count}, 32'd1);

        // Asynchronous reset in the middle of a run, then a clean restart
        push_exp(8'h60);
        start_pc = 8'h60; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_count", {16'd0, fetch_count}, 32'd0);
        chk("ar_rom_addr", {24'd0, rom_addr}, 32'd0);
        chk("ar_instr_pc", {24'd0, instr_pc}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_idle", {30'd0, busy, halted}, 32'd0);
        chk("ar_sb_empty", sb_q.size(), 32'd0);
        run_vec(8'hA0, 3, 16'd3, 8'hA3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
